mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Sits between the multi-cycle MIPS controller/datapath and the unified word-addressed Memory.
//  Memory has async read, sync write on posedge clk, word index = address[31:2].
//  Turns lw/lh/lhu/lb/lbu/sw/sh/sb requests into word accesses; sb/sh use read-modify-write.
//  Returns extracted, sign/zero-extended load data with a one-cycle done pulse.
// PARAMETERS
//  BIG_ENDIAN  0  byte-lane order; 0: byte offset 0 = bits[7:0], 1: byte offset 0 = bits[31:24]
// PORTS
//  clk         in   1   system clock, rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  req         in   1   request strobe; accepted only when ready=1
//  ready       out  1   high in IDLE only
//  req_we      in   1   1=store, 0=load
//  req_size    in   2   00=byte, 01=half, 10=word, 11=illegal (treated as misaligned)
//  req_signed  in   1   loads: 1=sign-extend, 0=zero-extend; ignored for stores/word
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  rdata       out  32  load result; held until the next completed load
//  done        out  1   1-cycle pulse when an accepted access completes
//  err         out  1   1-cycle pulse: misaligned/illegal request rejected
//  mem_addr    out  32  to Memory address
//  mem_wd      out  32  to Memory wd
//  mem_we      out  1   to Memory we
//  mem_rd      in   32  from Memory rd (combinational from mem_addr)
// BEHAVIOUR
//  Reset (async): state=IDLE; rdata, done, err, mem_addr, mem_wd, mem_we, internal regs = 0.
//  mem_we is decoded from state only and falls with reset immediately.
//  States: IDLE, LOAD, MERGE, STORE.
//  IDLE: ready=1, mem_we=0. On req, latch addr/size/signed/wdata.
//   Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
//   Misaligned -> err=1 next cycle, stay IDLE, no memory access, no done.
//   Otherwise: load -> LOAD; word store -> STORE; byte/half store -> MERGE.
//  LOAD: mem_addr=latched addr. At the edge:
//   rdata <= lane(mem_rd, addr[1:0], size) extended per signed; done<=1; -> IDLE.
//  MERGE: mem_addr driven, mem_we=0. At the edge:
//   wbuf <= mem_rd with the addressed byte/half lanes replaced by wdata; -> STORE.
//  STORE: mem_addr driven, mem_wd = wbuf (or wdata for sw), mem_we=1 for exactly this cycle.
//   At the edge: done<=1; -> IDLE.
//  Latency req-edge to done high: load 2 cycles, sw 2, sb/sh 3.
//   Back-to-back: the next req is accepted on the cycle done is high.
//  req while ready=0: ignored, not queued. Controller holds nothing after acceptance.
//  Half lanes: addr[1]=0 -> low half (LE), addr[1]=1 -> high half; BIG_ENDIAN mirrors.
//  rdata unchanged by stores, errors and rejected requests.
//  done and err never high together. err does not change ready.
//  mem_addr keeps its last latched value in IDLE. Memory's word index ignores addr[1:0].
//  Reset mid-MERGE/STORE: the write is abandoned (no partial write if reset precedes the STORE edge).
// STRUCTURE
//  Package mips_mem_pkg: SIZE_BYTE/SIZE_HALF/SIZE_WORD localparams, state encoding, misalign function.
//  Sub-module mem_lane_align (combinational): extract+extend for loads, lane merge for stores,
//   parameterised by BIG_ENDIAN. Top level holds FSM and registers only.
// TESTING (Memory model preloaded: word 0x100 = 0x11223344, word 0x104 = 0x80FF7F01, LE)
//  lw 0x100 -> done 2 cycles after req, rdata=0x11223344, mem_we never high.
//  lb 0x107 signed -> rdata=0x80 sign-extended = 0xFFFFFF80; lbu 0x107 -> 0x00000080;
//   lh 0x104 signed -> 0x00007F01.
//  sb 0x101 wdata 0x000000AB -> mem_we high exactly 1 cycle, word 0x100 = 0x1122AB44, done at +3.
//  sh 0x102 wdata 0x0000BEEF -> word 0x100 = 0xBEEF3344; then sw 0x100 0xDEADBEEF
//   issued on the done cycle -> accepted, word = 0xDEADBEEF.
//  lw 0x102 / lh 0x101 / size=11 -> err pulse 1 cycle, no done, no mem_we, rdata unchanged.
//  rst_n low during MERGE of sb 0x100 -> outputs 0 at once, mem_we never asserts,
//   word 0x100 unchanged, ready=1 after release.

Source files
------------

// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mips_mem_pkg
//  Purpose : Shared definitions for the memory access unit: access-size codes,
//            FSM state encoding and the alignment check used at request time.
//  Ports   : none (package)
//  Revision: 1.0  initial release
// ============================================================================
package mips_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_MERGE = 2'd2,
        ST_STORE = 2'd3
    } state_e;

    // Illegal size code is folded into the misaligned class so it takes the
    // same reject path.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic r;
        case (size)
            SIZE_BYTE: r = 1'b0;
            SIZE_HALF: r = addr_lo[0];
            SIZE_WORD: r = |addr_lo;
            default:   r = 1'b1;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module  : mem_access_unit_if
//  Purpose : Request/response bus between the controller and the memory
//            access unit.
//  Signals : req/req_we/req_size/req_signed/req_addr/req_wdata (controller ->
//            unit), ready/rdata/done/err (unit -> controller)
//  Modports: master = controller side, slave = memory access unit side
//  Revision: 1.0  initial release
// ============================================================================
interface mem_access_unit_if;
    logic        req;
    logic        ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        done;
    logic        err;

    modport master (
        output req, req_we, req_size, req_signed, req_addr, req_wdata,
        input  ready, rdata, done, err
    );

    modport slave (
        input  req, req_we, req_size, req_signed, req_addr, req_wdata,
        output ready, rdata, done, err
    );
endinterface
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module  : mem_lane_align
//  Purpose : Combinational byte-lane logic. Extracts and sign/zero-extends a
//            byte/half/word from a memory word for loads, and merges
//            right-justified store data into a memory word for sub-word stores.
//  Ports   : i_rd_word    memory word read
//            i_addr_lo    byte address bits [1:0]
//            i_size       access size code
//            i_signed     1 = sign-extend load result
//            i_wdata      right-justified store data
//            o_load_data  extracted, extended load value
//            o_merge_word i_rd_word with the addressed lanes replaced
//  Revision: 1.0  initial release
// ============================================================================
module mem_lane_align
    import mips_mem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  wire logic [31:0] i_rd_word,
    input  wire logic [1:0]  i_addr_lo,
    input  wire logic [1:0]  i_size,
    input  wire logic        i_signed,
    input  wire logic [31:0] i_wdata,
    output logic      [31:0] o_load_data,
    output logic      [31:0] o_merge_word
);

    logic [1:0]  w_byte_idx;
    logic        w_half_idx;
    logic [4:0]  w_shift;
    logic [31:0] w_lane;
    logic [31:0] w_mask;
    logic [31:0] w_mask_sh;
    logic [31:0] w_ins_sh;

    always_comb begin
        // Big-endian places offset 0 in the top lane: the lane index is the
        // bitwise complement of the offset (3-o for bytes, 1-o for halves).
        w_byte_idx = BIG_ENDIAN ? ~i_addr_lo    : i_addr_lo;
        w_half_idx = BIG_ENDIAN ? ~i_addr_lo[1] : i_addr_lo[1];

        case (i_size)
            SIZE_BYTE: begin
                w_shift = {w_byte_idx, 3'b000};
                w_mask  = 32'h0000_00FF;
            end
            SIZE_HALF: begin
                w_shift = {w_half_idx, 4'b0000};
                w_mask  = 32'h0000_FFFF;
            end
            default: begin
                w_shift = 5'd0;
                w_mask  = 32'hFFFF_FFFF;
            end
        endcase

        w_lane = i_rd_word >> w_shift;

        case (i_size)
            SIZE_BYTE: o_load_data = {{24{i_signed & w_lane[7]}},  w_lane[7:0]};
            SIZE_HALF: o_load_data = {{16{i_signed & w_lane[15]}}, w_lane[15:0]};
            default:   o_load_data = i_rd_word;
        endcase

        w_mask_sh    = w_mask << w_shift;
        w_ins_sh     = (i_wdata & w_mask) << w_shift;
        o_merge_word = (i_rd_word & ~w_mask_sh) | w_ins_sh;
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module  : mem_access_unit
//  Purpose : Converts byte/half/word load and store requests from the
//            multi-cycle controller into word accesses on a memory with async
//            read and sync write. Sub-word stores use read-modify-write.
//  Ports   : clk, rst_n          clock, async active-low reset
//            bus (slave)         request/response handshake
//            mem_addr/mem_wd/mem_we -> memory, mem_rd <- memory
//  Revision: 1.0  initial release
// ============================================================================
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    mem_access_unit_if.slave bus,
    output logic      [31:0] mem_addr,
    output logic      [31:0] mem_wd,
    output logic             mem_we,
    input  wire logic [31:0] mem_rd
);

    state_e      state_q,  state_d;
    logic [31:0] addr_q,   addr_d;
    logic [1:0]  size_q,   size_d;
    logic        signed_q, signed_d;
    logic [31:0] wbuf_q,   wbuf_d;
    logic [31:0] rdata_q,  rdata_d;
    logic        done_q,   done_d;
    logic        err_q,    err_d;

    logic [31:0] w_load_data;
    logic [31:0] w_merge_word;

    mem_lane_align #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_align (
        .i_rd_word    (mem_rd),
        .i_addr_lo    (addr_q[1:0]),
        .i_size       (size_q),
        .i_signed     (signed_q),
        .i_wdata      (wbuf_q),
        .o_load_data  (w_load_data),
        .o_merge_word (w_merge_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= 32'd0;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            wbuf_q   <= 32'd0;
            rdata_q  <= 32'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            wbuf_q   <= wbuf_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        signed_d = signed_q;
        wbuf_d   = wbuf_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    addr_d   = bus.req_addr;
                    size_d   = bus.req_size;
                    signed_d = bus.req_signed;
                    // wbuf holds the raw store data until MERGE overwrites it
                    // with the merged word; a word store writes it directly.
                    wbuf_d   = bus.req_wdata;
                    if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
                        err_d = 1'b1;
                    end else if (!bus.req_we) begin
                        state_d = ST_LOAD;
                    end else if (bus.req_size == SIZE_WORD) begin
                        state_d = ST_STORE;
                    end else begin
                        state_d = ST_MERGE;
                    end
                end
            end
            ST_LOAD: begin
                rdata_d = w_load_data;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_MERGE: begin
                wbuf_d  = w_merge_word;
                state_d = ST_STORE;
            end
            ST_STORE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.ready = (state_q == ST_IDLE);
    assign bus.rdata = rdata_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;

    // Write enable comes straight from the state register so an async reset
    // drops it immediately, abandoning any pending write.
    assign mem_addr  = addr_q;
    assign mem_wd    = wbuf_q;
    assign mem_we    = (state_q == ST_STORE);

endmodule
`default_nettype wire
